// File: rtl/alu_bist_if.sv
// ALU request/response bundle between the BIST initiator (master) and the ALU (slave).
interface alu_bist_if;
   logic [31:0] src_A;
   logic [31:0] src_B;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        zero;

   modport master (output src_A, output src_B, output alu_op, input alu_result, input zero);
   modport slave  (input src_A, input src_B, input alu_op, output alu_result, output zero);
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test initiator for the RV32I ALU: replays a vector ROM and reports pass/fail.
// Optional macro ALU_BIST_HALT_ON_FAIL_EN stops the run at the first mismatching vector.
module alu_bist #(
   parameter int NUM_VECTORS   = 11,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   alu_bist_if.master  bus,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic [5:0]  o_fail_count,
   output logic [3:0]  o_first_fail_idx,
   output logic [31:0] o_fail_result
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
   } stim_t;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
   } expect_t;

   localparam int         CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [3:0] LAST_IDX    = 4'(NUM_VECTORS - 1);
   localparam logic [3:0] OP_NOP      = 4'b1111;
   localparam logic [5:0] FC_MAX      = 6'd63;

   function automatic stim_t rom_stim(input logic [3:0] idx);
      case (idx)
         4'd0:    rom_stim = {32'd1972,       32'd1121,       4'b0000};
         4'd1:    rom_stim = {32'd30,         32'd30,         4'b0001};
         4'd2:    rom_stim = {32'hF0F0_F0F0,  32'h0F0F_0F0F,  4'b0010};
         4'd3:    rom_stim = {32'hF0F0_F0F0,  32'h0F0F_0F0F,  4'b0011};
         4'd4:    rom_stim = {32'h7777_7777,  32'hEF07_189A,  4'b0100};
         4'd5:    rom_stim = {32'h0000_0000,  32'hF000_0001,  4'b0101};
         4'd6:    rom_stim = {32'hF000_0000,  32'hF000_0001,  4'b0110};
         4'd7:    rom_stim = {32'h0FFF_FFFF,  32'd3,          4'b0111};
         4'd8:    rom_stim = {32'hDEAD_BEEF,  32'd8,          4'b1000};
         4'd9:    rom_stim = {32'hFDEA_DBEF,  32'd4,          4'b1001};
         4'd10:   rom_stim = {32'hFFFF_FFFF,  32'h0FF0_0FF0,  4'b1010};
         default: rom_stim = {32'h0000_0000,  32'h0000_0000,  OP_NOP};
      endcase
   endfunction

   function automatic expect_t rom_exp(input logic [3:0] idx);
      case (idx)
         4'd0:    rom_exp = {32'h0000_0C15, 1'b0};
         4'd1:    rom_exp = {32'h0000_0000, 1'b1};
         4'd2:    rom_exp = {32'h0000_0000, 1'b1};
         4'd3:    rom_exp = {32'hFFFF_FFFF, 1'b0};
         4'd4:    rom_exp = {32'h9870_6FED, 1'b0};
         4'd5:    rom_exp = {32'h0000_0000, 1'b1};
         4'd6:    rom_exp = {32'h0000_0001, 1'b0};
         4'd7:    rom_exp = {32'h7FFF_FFF8, 1'b0};
         4'd8:    rom_exp = {32'h00DE_ADBE, 1'b0};
         4'd9:    rom_exp = {32'hFFDE_ADBE, 1'b0};
         4'd10:   rom_exp = {32'hF00F_F00F, 1'b0};
         default: rom_exp = {32'h0000_0000, 1'b0};
      endcase
   endfunction

   state_t         r_state, w_state;
   logic [CW-1:0]  r_cnt, w_cnt;
   logic [3:0]     r_idx, w_idx;
   logic [31:0]    r_src_a, w_src_a;
   logic [31:0]    r_src_b, w_src_b;
   logic [3:0]     r_alu_op, w_alu_op;
   logic           r_busy, w_busy;
   logic           r_done, w_done;
   logic           r_pass, w_pass;
   logic [5:0]     r_fail_count, w_fail_count;
   logic [3:0]     r_first_fail_idx, w_first_fail_idx;
   logic [31:0]    r_fail_result, w_fail_result;

   logic [3:0]     w_load_idx;
   stim_t          w_stim;
   expect_t        w_exp;
   logic           w_mismatch;
   logic           w_halt;
   logic [5:0]     w_fc_chk;

   // Next-state and next-output logic; every register holds unless a branch updates it.
   always_comb begin
      w_state          = r_state;
      w_cnt            = r_cnt;
      w_idx            = r_idx;
      w_src_a          = r_src_a;
      w_src_b          = r_src_b;
      w_alu_op         = r_alu_op;
      w_busy           = r_busy;
      w_done           = r_done;
      w_pass           = r_pass;
      w_fail_count     = r_fail_count;
      w_first_fail_idx = r_first_fail_idx;
      w_fail_result    = r_fail_result;

      // CHECK loads the following vector; a start always loads vector 0.
      w_load_idx = (r_state == S_CHECK) ? (r_idx + 4'd1) : 4'd0;
      w_stim     = rom_stim(w_load_idx);
      w_exp      = rom_exp(r_idx);
      w_mismatch = (bus.alu_result != w_exp.res) || (bus.zero != w_exp.z);
      if (w_mismatch) begin
         w_fc_chk = (r_fail_count == FC_MAX) ? r_fail_count : (r_fail_count + 6'd1);
      end else begin
         w_fc_chk = r_fail_count;
      end
`ifdef ALU_BIST_HALT_ON_FAIL_EN
      w_halt = w_mismatch;
`else
      w_halt = 1'b0;
`endif

      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_state          = S_SETTLE;
               w_cnt            = '0;
               w_idx            = 4'd0;
               w_src_a          = w_stim.a;
               w_src_b          = w_stim.b;
               w_alu_op         = w_stim.op;
               w_busy           = 1'b1;
               w_done           = 1'b0;
               w_pass           = 1'b0;
               w_fail_count     = 6'd0;
               w_first_fail_idx = 4'd0;
               w_fail_result    = 32'd0;
            end else begin
               w_state = r_state;
            end
         end
         S_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
               w_state = S_CHECK;
            end else begin
               w_cnt = r_cnt + CW'(1'b1);
            end
         end
         S_CHECK: begin
            w_fail_count = w_fc_chk;
            if (w_mismatch && (r_fail_count == 6'd0)) begin
               w_first_fail_idx = r_idx;
               w_fail_result    = bus.alu_result;
            end else begin
               w_first_fail_idx = r_first_fail_idx;
            end
            if ((r_idx == LAST_IDX) || w_halt) begin
               w_state  = S_DONE;
               w_busy   = 1'b0;
               w_done   = 1'b1;
               w_pass   = (w_fc_chk == 6'd0);
               w_src_a  = 32'd0;
               w_src_b  = 32'd0;
               w_alu_op = OP_NOP;
            end else begin
               w_state  = S_SETTLE;
               w_cnt    = '0;
               w_idx    = r_idx + 4'd1;
               w_src_a  = w_stim.a;
               w_src_b  = w_stim.b;
               w_alu_op = w_stim.op;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         r_idx            <= 4'd0;
         r_src_a          <= 32'd0;
         r_src_b          <= 32'd0;
         r_alu_op         <= OP_NOP;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_pass           <= 1'b0;
         r_fail_count     <= 6'd0;
         r_first_fail_idx <= 4'd0;
         r_fail_result    <= 32'd0;
      end else begin
         r_state          <= w_state;
         r_cnt            <= w_cnt;
         r_idx            <= w_idx;
         r_src_a          <= w_src_a;
         r_src_b          <= w_src_b;
         r_alu_op         <= w_alu_op;
         r_busy           <= w_busy;
         r_done           <= w_done;
         r_pass           <= w_pass;
         r_fail_count     <= w_fail_count;
         r_first_fail_idx <= w_first_fail_idx;
         r_fail_result    <= w_fail_result;
      end
   end

   assign bus.src_A        = r_src_a;
   assign bus.src_B        = r_src_b;
   assign bus.alu_op       = r_alu_op;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_pass           = r_pass;
   assign o_fail_count     = r_fail_count;
   assign o_first_fail_idx = r_first_fail_idx;
   assign o_fail_result    = r_fail_result;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a fault-injectable ALU model drives two DUTs (SETTLE_CYCLES 1 and 3),
// and a run-level reference model predicts every output on every cycle.
module tb_alu_bist;
   localparam int NV = 11;
`ifdef ALU_BIST_HALT_ON_FAIL_EN
   localparam bit HALT = 1'b1;
`else
   localparam bit HALT = 1'b0;
`endif

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        pass;
      logic [5:0]  fc;
      logic [3:0]  ffi;
      logic [31:0] fres;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic start;
   always #5 clk = ~clk;

   alu_bist_if if1 ();
   alu_bist_if if3 ();

   logic        o1_busy, o1_done, o1_pass, o3_busy, o3_done, o3_pass;
   logic [5:0]  o1_fc, o3_fc;
   logic [3:0]  o1_ffi, o3_ffi;
   logic [31:0] o1_fres, o3_fres;

   alu_bist #(.NUM_VECTORS(NV), .SETTLE_CYCLES(1)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_start(start), .bus(if1),
      .o_busy(o1_busy), .o_done(o1_done), .o_pass(o1_pass), .o_fail_count(o1_fc),
      .o_first_fail_idx(o1_ffi), .o_fail_result(o1_fres));

   alu_bist #(.NUM_VECTORS(NV), .SETTLE_CYCLES(3)) dut3 (
      .i_clk(clk), .i_reset(reset), .i_start(start), .bus(if3),
      .o_busy(o3_busy), .o_done(o3_done), .o_pass(o3_pass), .o_fail_count(o3_fc),
      .o_first_fail_idx(o3_ffi), .o_fail_result(o3_fres));

   logic [31:0] rom_a [NV];
   logic [31:0] rom_b [NV];
   logic [31:0] rom_res [NV];
   logic [3:0]  rom_op [NV];
   logic        rom_z [NV];
   logic [31:0] f_mask [16];
   int          zmode = 0;          // 0 real zero flag, 1 stuck at 0, 2 stuck at 1
   int          n_checks = 0;
   int          n_err = 0;

   function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      case (op)
         4'd0:    golden = a + b;
         4'd1:    golden = a - b;
         4'd2:    golden = a & b;
         4'd3:    golden = a | b;
         4'd4:    golden = a ^ b;
         4'd5:    golden = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    golden = (a < b) ? 32'd1 : 32'd0;
         4'd7:    golden = a << b[4:0];
         4'd8:    golden = a >> b[4:0];
         4'd9:    golden = 32'($signed(a) >>> b[4:0]);
         4'd10:   golden = a & ~b;
         default: golden = 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] alu_res(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      alu_res = golden(a, b, op) ^ f_mask[op];
   endfunction

   function automatic logic alu_zero(input logic [31:0] r);
      alu_zero = (zmode == 1) ? 1'b0 : (zmode == 2) ? 1'b1 : (r == 32'd0);
   endfunction

   // Fault-injectable combinational ALUs
   always_comb begin
      if1.alu_result = alu_res(if1.src_A, if1.src_B, if1.alu_op);
      if1.zero       = alu_zero(alu_res(if1.src_A, if1.src_B, if1.alu_op));
      if3.alu_result = alu_res(if3.src_A, if3.src_B, if3.alu_op);
      if3.zero       = alu_zero(alu_res(if3.src_A, if3.src_B, if3.alu_op));
   end

   function automatic logic [NV-1:0] snap_mism();
      logic [31:0] r;
      snap_mism = '0;
      for (int j = 0; j < NV; j++) begin
         r = alu_res(rom_a[j], rom_b[j], rom_op[j]);
         snap_mism[j] = (r != rom_res[j]) || (alu_zero(r) != rom_z[j]);
      end
   endfunction

   function automatic logic [NV-1:0][31:0] snap_resp();
      for (int j = 0; j < NV; j++) snap_resp[j] = alu_res(rom_a[j], rom_b[j], rom_op[j]);
   endfunction

   function automatic int nrun_of(input logic [NV-1:0] mism);
      nrun_of = NV;
      if (HALT) begin
         for (int j = NV - 1; j >= 0; j--) if (mism[j]) nrun_of = j + 1;
      end
   endfunction

   // Run-level expectation: st 0 idle, 1 running k cycles after the start edge, 2 done
   function automatic exp_t expect_of(input int st, input int k, input int s,
                                      input logic [NV-1:0] mism, input logic [NV-1:0][31:0] resp);
      exp_t e;
      int   nchk;
      e = '0;
      e.op = 4'hF;
      nchk = 0;
      if (st == 1) begin
         nchk = k / (s + 1);
         e.busy = 1'b1;
         e.a = rom_a[nchk];
         e.b = rom_b[nchk];
         e.op = rom_op[nchk];
      end else if (st == 2) begin
         nchk = nrun_of(mism);
         e.done = 1'b1;
      end
      for (int j = 0; j < nchk; j++) begin
         if (mism[j]) begin
            if (e.fc == 6'd0) begin
               e.ffi = 4'(j);
               e.fres = resp[j];
            end
            e.fc = e.fc + 6'd1;
         end
      end
      if (st == 2) e.pass = (e.fc == 6'd0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   int                    m_st [2] = '{0, 0};
   int                    m_k [2] = '{0, 0};
   logic [NV-1:0]         m_mism [2];
   logic [NV-1:0][31:0]   m_resp [2];

   // Reference model: tracks each DUT's run at the level of start, elapsed cycles and end of run
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_st[d] <= 0;
            m_k[d] <= 0;
         end else if (m_st[d] != 1 && start) begin
            m_st[d] <= 1;
            m_k[d] <= 0;
            m_mism[d] <= snap_mism();
            m_resp[d] <= snap_resp();
         end else if (m_st[d] == 1) begin
            m_k[d] <= m_k[d] + 1;
            if (m_k[d] + 1 == nrun_of(m_mism[d]) * ((d == 0) ? 2 : 4)) m_st[d] <= 2;
         end
      end
   end

   // Cycle-by-cycle compare of both DUTs against the model
   always @(negedge clk) begin
      exp_t e1, e3;
      e1 = expect_of(m_st[0], m_k[0], 1, m_mism[0], m_resp[0]);
      e3 = expect_of(m_st[1], m_k[1], 3, m_mism[1], m_resp[1]);
      chk("d1_busy", 32'(o1_busy), 32'(e1.busy));
      chk("d1_done", 32'(o1_done), 32'(e1.done));
      chk("d1_pass", 32'(o1_pass), 32'(e1.pass));
      chk("d1_fail_count", 32'(o1_fc), 32'(e1.fc));
      chk("d1_first_fail_idx", 32'(o1_ffi), 32'(e1.ffi));
      chk("d1_fail_result", o1_fres, e1.fres);
      chk("d1_src_A", if1.src_A, e1.a);
      chk("d1_src_B", if1.src_B, e1.b);
      chk("d1_alu_op", 32'(if1.alu_op), 32'(e1.op));
      chk("d3_busy", 32'(o3_busy), 32'(e3.busy));
      chk("d3_done", 32'(o3_done), 32'(e3.done));
      chk("d3_pass", 32'(o3_pass), 32'(e3.pass));
      chk("d3_fail_count", 32'(o3_fc), 32'(e3.fc));
      chk("d3_first_fail_idx", 32'(o3_ffi), 32'(e3.ffi));
      chk("d3_fail_result", o3_fres, e3.fres);
      chk("d3_src_A", if3.src_A, e3.a);
      chk("d3_src_B", if3.src_B, e3.b);
      chk("d3_alu_op", 32'(if3.alu_op), 32'(e3.op));
   end

   // Pulse start, optionally re-pulse start or assert reset at given cycles, measure done latency
   task automatic run_one(input int rp_a, input int rp_b, input int rst_at, output int lat1, output int lat3);
      int n;
      lat1 = -1;
      lat3 = -1;
      n = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      while ((lat1 < 0 || lat3 < 0) && n < 300) begin
         @(negedge clk);
         start = (n + 1 == rp_a) || (n + 1 == rp_b);
         reset = (n + 1 == rst_at);
         @(posedge clk);
         n++;
         #1;
         if (reset) begin
            chk("rst_busy", 32'({o1_busy, o3_busy}), 32'd0);
            chk("rst_done", 32'({o1_done, o3_done}), 32'd0);
            chk("rst_alu_op", 32'({if1.alu_op, if3.alu_op}), 32'hFF);
            chk("rst_src", if1.src_A | if1.src_B | if3.src_A | if3.src_B, 32'd0);
            chk("rst_fail_count", 32'({o1_fc, o3_fc}), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            return;
         end
         if (o1_done && lat1 < 0) lat1 = n;
         if (o3_done && lat3 < 0) lat3 = n;
      end
      @(negedge clk);
      start = 1'b0;
      chk("run_timeout", 32'(n >= 300), 32'd0);
   endtask

   initial begin
      int l1, l3, nr, rpa, rpb, rst;
      reset = 1'b1;
      start = 1'b0;
      for (int o = 0; o < 16; o++) f_mask[o] = 32'd0;
      rom_a = '{32'd1972, 32'd30, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h77777777, 32'h0,
                32'hF0000000, 32'h0FFFFFFF, 32'hDEADBEEF, 32'hFDEADBEF, 32'hFFFFFFFF};
      rom_b = '{32'd1121, 32'd30, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'hEF07189A, 32'hF0000001,
                32'hF0000001, 32'd3, 32'd8, 32'd4, 32'h0FF00FF0};
      rom_op = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
      rom_res = '{32'h00000C15, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h98706FED, 32'h0,
                  32'h1, 32'h7FFFFFF8, 32'h00DEADBE, 32'hFFDEADBE, 32'hF00FF00F};
      rom_z = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      // The bench ALU must reproduce the vector table when fault-free
      for (int j = 0; j < NV; j++) chk("model_alu", golden(rom_a[j], rom_b[j], rom_op[j]), rom_res[j]);
      chk("model_clean", 32'(snap_mism()), 32'd0);

      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset_alu_op", 32'(if1.alu_op), 32'hF);
      chk("reset_status", 32'({o1_busy, o1_done, o1_pass, o1_fc, o1_ffi}), 32'd0);

      // Fault-free run
      run_one(0, 0, 0, l1, l3);
      chk("clean_lat1", 32'(l1), 32'd22);
      chk("clean_lat3", 32'(l3), 32'd44);
      chk("clean_pass", 32'({o1_pass, o3_pass}), 32'd3);
      chk("clean_result", 32'({o1_fc, o1_ffi}) | o1_fres, 32'd0);

      // Zero flag stuck at 0
      zmode = 1;
      run_one(0, 0, 0, l1, l3);
      chk("z0_lat1", 32'(l1), HALT ? 32'd4 : 32'd22);
      chk("z0_fail_count", 32'(o1_fc), HALT ? 32'd1 : 32'd3);
      chk("z0_first_idx", 32'(o1_ffi), 32'd1);
      chk("z0_fail_result", o1_fres, 32'd0);
      chk("z0_pass", 32'(o1_pass), 32'd0);
      zmode = 0;

      // ADD result bit 0 inverted
      f_mask[0] = 32'd1;
      run_one(0, 0, 0, l1, l3);
      chk("add_lat1", 32'(l1), HALT ? 32'd2 : 32'd22);
      chk("add_lat3", 32'(l3), HALT ? 32'd4 : 32'd44);
      chk("add_fail_count", 32'(o1_fc), 32'd1);
      chk("add_first_idx", 32'(o1_ffi), 32'd0);
      chk("add_fail_result", o1_fres, 32'h00000C14);
      f_mask[0] = 32'd0;

      // Start re-pulsed mid-run is ignored; a start from DONE runs again cleanly
      run_one(5, 10, 0, l1, l3);
      chk("repulse_lat1", 32'(l1), 32'd22);
      chk("repulse_lat3", 32'(l3), 32'd44);
      run_one(0, 0, 0, l1, l3);
      chk("rerun_lat1", 32'(l1), 32'd22);
      chk("rerun_pass", 32'(o1_pass), 32'd1);

      // Reset mid-run, then a clean run
      run_one(0, 0, 9, l1, l3);
      run_one(0, 0, 0, l1, l3);
      chk("after_rst_lat1", 32'(l1), 32'd22);
      chk("after_rst_pass", 32'({o1_pass, o3_pass}), 32'd3);

      // Randomized fault patterns, re-pulses and resets
      for (int r = 0; r < 24; r++) begin
         zmode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         for (int o = 0; o < 16; o++)
            f_mask[o] = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
         nr  = nrun_of(snap_mism());
         rpa = int'($urandom_range(1, 2 * nr - 1));
         rpb = int'($urandom_range(1, 2 * nr - 1));
         rst = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2 * nr)) : 0;
         run_one(rpa, rpb, rst, l1, l3);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Synthesizable built-in self-test initiator for the RV32I ALU.
- Sits on the requester side of the ALU interface: drives src_A/src_B/alu_op from an internal vector ROM, samples alu_result/zero, compares against stored expectations, and reports pass/fail.
- Used for power-on ALU check and for bring-up on FPGA, where no simulator testbench is available.

Parameters:
- NUM_VECTORS, 11, number of ROM vectors executed, indices 0..NUM_VECTORS-1; legal range 1..11.
- SETTLE_CYCLES, 1, cycles operands are held before the result is sampled; must be >=1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to run the test; sampled only in IDLE or DONE
- alu_result  input  32  result returned by the ALU
- zero  input  1  zero flag returned by the ALU
- src_A  output  32  operand A to the ALU, registered
- src_B  output  32  operand B to the ALU, registered
- alu_op  output  4  ALU opcode, registered
- busy  output  1  high while vectors are executing
- done  output  1  high from test completion until the next start or reset
- pass  output  1  valid when done=1; high iff fail_count==0
- fail_count  output  6  number of mismatching vectors in the last run
- first_fail_idx  output  4  index of the first mismatching vector; 0 if none
- fail_result  output  32  alu_result captured at first mismatch; 0 if none

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: src_A=0, src_B=0, alu_op=4'b1111 (NOP), busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0, fail_result=0. FSM goes to IDLE.
- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, ABJ 1010, NOP 1111.
- ROM fields per vector: {A, B, op, expected result, expected zero}.
  - 0 ADD 1972, 1121 -> 0x00000C15, z0
  - 1 SUB 30, 30 -> 0, z1
  - 2 AND F0F0F0F0, 0F0F0F0F -> 0, z1
  - 3 OR F0F0F0F0, 0F0F0F0F -> FFFFFFFF, z0
  - 4 XOR 77777777, EF07189A -> 98706FED, z0
  - 5 SLT 00000000, F0000001 -> 0, z1
  - 6 SLTU F0000000, F0000001 -> 1, z0
  - 7 SLL 0FFFFFFF, 3 -> 7FFFFFF8, z0
  - 8 SRL DEADBEEF, 8 -> 00DEADBE, z0
  - 9 SRA FDEADBEF, 4 -> FFDEADBE, z0
  - 10 ABJ FFFFFFFF, 0FF00FF0 -> F00FF00F, z0
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1, on the next edge:
  - idx<-0; src_A/src_B/alu_op<-vector 0
  - fail_count, first_fail_idx and fail_result cleared; done<-0, pass<-0, busy<-1
  - state<-SETTLE, settle counter<-0
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, state<-CHECK.
- CHECK:
  - Mismatch = (alu_result!=exp_result) or (zero!=exp_zero).
  - On mismatch, fail_count increments, saturating at 63.
  - On the first mismatch of a run, first_fail_idx<-idx and fail_result<-alu_result.
  - If idx==NUM_VECTORS-1: state<-DONE, busy<-0, done<-1, pass<-(final fail_count==0, including this vector), operands<-0, alu_op<-NOP.
  - Otherwise: idx++, load next vector onto outputs, state<-SETTLE.
- Latency: (SETTLE_CYCLES+1) cycles per vector. Default 11 vectors: done rises 22 cycles after the start edge.
- start while busy=1 is ignored. start in DONE restarts a fresh run.
- reset mid-run aborts immediately to reset values. No partial result is retained.
- ALU is combinational. Outputs stay stable from load through CHECK, so sampling in CHECK sees the settled result.

Optional Feature:
- Macro: ALU_BIST_HALT_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes straight to DONE with pass=0, fail_count=1, first_fail_idx/fail_result captured, operands zeroed and alu_op=NOP. Remaining vectors are skipped.
- Undefined: all NUM_VECTORS vectors always run and every mismatch is counted.

Test Plan:
- Reference-correct ALU, pulse start -> busy for 22 cycles; done=1, pass=1, fail_count=0, first_fail_idx=0, fail_result=0.
- ALU zero flag stuck at 0 -> done after 22 cycles; pass=0, fail_count=3 (vectors 1, 2, 5), first_fail_idx=1, fail_result=0.
- ALU result bit0 inverted only for ADD -> fail_count=1, first_fail_idx=0, fail_result=0x00000C14. With ALU_BIST_HALT_ON_FAIL_EN: done 2 cycles after start, fail_count=1.
- start re-pulsed at cycles 5 and 10 of a run -> ignored; done still at cycle 22. Another start after done -> counters cleared, a second identical run follows.
- reset asserted at cycle 9 of a run -> next edge all outputs at reset values (alu_op=1111, busy=0, done=0). Following start runs cleanly to pass=1.
- SETTLE_CYCLES=3 -> operands held 4 cycles per vector; done at cycle 44 with pass=1.
